booth_mul_sched: RTL and testbench

BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

---
 rtl/booth_mul_sched_if.sv | 39 +++
 rtl/booth_mul_sched.sv | 117 +++++++++++
 tb/tb_booth_mul_sched.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_sched_if.sv
// Handshake, multiplier and status bundle for booth_mul_sched.
// slave is the scheduler side, master is the requester/multiplier side.
interface booth_mul_sched_if;
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_ready;
    logic        rsp0_valid;
    logic [15:0] rsp0_prod;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic [15:0] rsp1_prod;
    logic        rsp1_ready;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_load;
    logic [15:0] mul_prod;
    logic        busy;
    logic        grant_id;
    logic [7:0]  done_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, mul_prod,
        output req0_ready, req1_ready, rsp0_valid, rsp0_prod, rsp1_valid, rsp1_prod,
        output mul_a, mul_b, mul_load, busy, grant_id, done_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, mul_prod,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_prod, rsp1_valid, rsp1_prod,
        input  mul_a, mul_b, mul_load, busy, grant_id, done_cnt
    );
endinterface

// File: rtl/booth_mul_sched.sv
// Two-requester round-robin scheduler in front of a shared sequential multiplier.
// One operation in flight: load, N_ITER run cycles, capture, then hold the response.
module booth_mul_sched #(
    parameter int N_ITER = 5
) (
    input  logic              clk,
    input  logic              rst,
    booth_mul_sched_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, RESP} state_t;
    localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic [7:0]    mul_a_q, mul_a_d;
    logic [7:0]    mul_b_q, mul_b_d;
    logic [15:0]   prod0_q, prod0_d;
    logic [15:0]   prod1_q, prod1_d;
    logic [7:0]    done_q, done_d;

    logic win;
    logic rdy0, rdy1;
    logic vld0, vld1;
    logic req_hs, rsp_hs;

    // With both valid the requester that did not go last wins; a lone requester always wins.
    assign win    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    // Ready is masked by rst so a handshake can never coincide with reset.
    assign rdy0   = (state_q == IDLE) && !rst && bus.req0_valid && !win;
    assign rdy1   = (state_q == IDLE) && !rst && bus.req1_valid && win;
    assign req_hs = (bus.req0_valid && rdy0) || (bus.req1_valid && rdy1);
    assign vld0   = (state_q == RESP) && !grant_q;
    assign vld1   = (state_q == RESP) && grant_q;
    assign rsp_hs = (vld0 && bus.rsp0_ready) || (vld1 && bus.rsp1_ready);

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp0_valid = vld0;
    assign bus.rsp1_valid = vld1;
    assign bus.rsp0_prod  = prod0_q;
    assign bus.rsp1_prod  = prod1_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.mul_load   = (state_q == LOAD);
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_q;
    assign bus.done_cnt   = done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        prod0_d      = prod0_q;
        prod1_d      = prod1_q;
        done_d       = done_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    mul_a_d      = win ? bus.req1_a : bus.req0_a;
                    mul_b_d      = win ? bus.req1_b : bus.req0_b;
                    grant_d      = win;
                    last_grant_d = win;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N_ITER - 1)) state_d = CAPT;
            end
            CAPT: begin
                if (grant_q) prod1_d = bus.mul_prod;
                else         prod0_d = bus.mul_prod;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    done_d  = done_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            prod0_q      <= '0;
            prod1_q      <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            prod0_q      <= prod0_d;
            prod1_q      <= prod1_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched: drivers push expected products on handshake,
// a monitor pops and compares on every response handshake.
module tb_booth_mul_sched;
    localparam int N_ITER = 5;

    typedef struct {
        bit          port;
        logic [15:0] prod;
        int          hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    booth_mul_sched_if bus ();

    booth_mul_sched #(.N_ITER(N_ITER)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          hs_last = -100;
    logic [7:0]  cur_a = '0;
    logic [7:0]  cur_b = '0;
    logic [15:0] model_prod [2];
    logic [7:0]  model_done = '0;
    int          bp_mode = 0;
    exp_t        sb[$];
    bit          resp_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'(b);
        return p[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Behavioural multiplier: operands sampled at load, product valid after N_ITER cycles.
    int         mcnt = 0;
    logic [7:0] ma, mb;
    always @(posedge clk) begin
        if (bus.mul_load) begin
            mcnt         <= N_ITER;
            ma           <= bus.mul_a;
            mb           <= bus.mul_b;
            bus.mul_prod <= 16'($urandom);
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) bus.mul_prod <= ref_prod(ma, mb);
        end
    end

    initial begin
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                1: begin
                    bus.rsp0_ready = ($urandom_range(0, 2) != 0);
                    bus.rsp1_ready = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    bus.rsp0_ready = 1'b0;
                    bus.rsp1_ready = 1'b1;
                end
                default: begin
                    bus.rsp0_ready = 1'b1;
                    bus.rsp1_ready = 1'b1;
                end
            endcase
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on response handshake.
    initial begin
        bit any, p, prev_any;
        prev_any = 0;
        model_prod[0] = '0;
        model_prod[1] = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                prev_any = 0;
                continue;
            end
            chk("one_ready", bus.req0_ready && bus.req1_ready, 0);
            chk("one_rsp_valid", bus.rsp0_valid && bus.rsp1_valid, 0);
            chk("mul_load", bus.mul_load, cyc == hs_last + 1);
            if (cyc != hs_last) begin
                chk("mul_a_hold", bus.mul_a, cur_a);
                chk("mul_b_hold", bus.mul_b, cur_b);
            end
            any = bus.rsp0_valid || bus.rsp1_valid;
            p   = bus.rsp1_valid;
            if (any) begin
                if (sb.size() == 0) begin
                    timeout("rsp_unexpected");
                end else begin
                    if (!prev_any) chk("latency", cyc, sb[0].hs + 3 + N_ITER);
                    chk("rsp_port", p, sb[0].port);
                    model_prod[p] = sb[0].prod;
                end
            end
            chk("rsp0_prod", bus.rsp0_prod, model_prod[0]);
            chk("rsp1_prod", bus.rsp1_prod, model_prod[1]);
            chk("done_cnt", bus.done_cnt, model_done);
            if (any && (p ? bus.rsp1_ready : bus.rsp0_ready) && sb.size() > 0) begin
                resp_log.push_back(p);
                void'(sb.pop_front());
                model_done = model_done + 8'd1;
            end
            prev_any = any;
        end
    end

    task automatic issue(input bit p, input logic [7:0] a, input logic [7:0] b);
        int   n;
        bit   got;
        exp_t e;
        n = 0;
        got = 0;
        @(posedge clk); #1;
        if (p) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            if ((p ? bus.req1_ready : bus.req0_ready) && !rst) begin
                e.port = p;
                e.prod = ref_prod(a, b);
                e.hs   = cyc;
                sb.push_back(e);
                hs_last = cyc;
                cur_a   = a;
                cur_b   = b;
                got     = 1;
            end
            n++;
        end
        if (!got) timeout("req_accept");
        @(posedge clk); #1;
        if (p) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bit ok;
        n = 0;
        ok = 0;
        while (!ok && n < 1000) begin
            @(negedge clk); #2;
            if (sb.size() == 0 && !bus.busy) ok = 1;
            n++;
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic clear_model();
        sb.delete();
        model_prod[0] = '0;
        model_prod[1] = '0;
        model_done    = '0;
        hs_last       = -100;
        cur_a         = '0;
        cur_b         = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_mul_a"}, bus.mul_a, 0);
        chk({nm, "_mul_b"}, bus.mul_b, 0);
        chk({nm, "_mul_load"}, bus.mul_load, 0);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_grant"}, bus.grant_id, 0);
        chk({nm, "_rsp_valid"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk({nm, "_prod"}, {bus.rsp0_prod, bus.rsp1_prod}, 0);
        chk({nm, "_done"}, bus.done_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Single op, expected product -3*7 = -21.
        bp_mode = 0;
        issue(0, 8'hFD, 8'h07);
        wait_idle();
        chk("single_prod", bus.rsp0_prod, 16'hFFEB);
        chk("single_done", bus.done_cnt, 1);

        // Contention right after reset: requester 0 first.
        do_reset();
        resp_log.delete();
        fork
            issue(0, 8'h02, 8'h03);
            issue(1, 8'h04, 8'h05);
        join
        wait_idle();
        chk("cont_count", resp_log.size(), 2);
        if (resp_log.size() >= 2) begin
            chk("cont_first", resp_log[0], 0);
            chk("cont_second", resp_log[1], 1);
        end
        chk("cont_prod0", bus.rsp0_prod, 16'h0006);
        chk("cont_prod1", bus.rsp1_prod, 16'h0014);
        chk("cont_grant", bus.grant_id, 1);

        // Backpressure with the most negative product; requester 1 waits meanwhile.
        bp_mode = 2;
        issue(0, 8'h80, 8'hFF);
        fork
            issue(1, 8'h11, 8'h22);
            begin
                n = 0;
                seen = 0;
                while (!seen && n < 50) begin
                    @(negedge clk);
                    seen = bus.rsp0_valid;
                    n++;
                end
                if (!seen) timeout("bp_rsp_valid");
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_prod", bus.rsp0_prod, 16'h8080);
                    chk("bp_busy", bus.busy, 1);
                    chk("bp_req1_ready", bus.req1_ready, 0);
                end
                bp_mode = 0;
            end
        join
        wait_idle();
        chk("bp_prod1", bus.rsp1_prod, ref_prod(8'h11, 8'h22));

        // Reset collides with a request: nothing is accepted.
        @(posedge clk); #1;
        rst = 1'b1;
        clear_model();
        bus.req1_valid = 1'b1; bus.req1_a = 8'h33; bus.req1_b = 8'h44;
        @(negedge clk);
        chk("rstprio_ready", bus.req1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("rstprio_busy", bus.busy, 0);
        repeat (12) @(posedge clk);

        // Reset during the third RUN cycle.
        issue(0, 8'h7F, 8'hFF);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_run");
        issue(1, 8'hC3, 8'h9A);
        wait_idle();

        // 256 alternating ops: done_cnt wraps back to zero.
        do_reset();
        resp_log.delete();
        for (int i = 0; i < 256; i++)
            issue(i[0], 8'($urandom), 8'($urandom));
        wait_idle();
        chk("wrap_done", bus.done_cnt, 0);
        chk("wrap_count", resp_log.size(), 256);

        // Random mix with random response backpressure.
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: issue(0, 8'($urandom), 8'($urandom));
                1: issue(1, 8'($urandom), 8'($urandom));
                default: fork
                    issue(0, 8'($urandom), 8'($urandom));
                    issue(1, 8'($urandom), 8'($urandom));
                join
            endcase
        end
        wait_idle();
        bp_mode = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
